pixel_sensor_controller: RTL and testbench



---
 rtl/pixel_sensor_controller_pkg.sv | 29 ++
 rtl/Counter.sv | 23 ++
 rtl/pixel_capture_bank.sv | 65 ++++++
 rtl/pixel_sensor_controller.sv | 176 +++++++++++++++++
 tb/tb_pixel_sensor_controller.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_sensor_controller_pkg.sv
// Shared configuration for the pixel sensor controller: code width, ramp
// length, erase length, controller states and the code presentation helper.
// Optional build macro: PIXEL_CTRL_SCENE_INVERT_EN (present inverted codes).
package PixelSensorConfig;

    localparam int PIXEL_BITS   = 8;
    localparam int RAMP_STEPS   = 2 ** PIXEL_BITS;
    localparam int ERASE_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_READOUT,
        ST_DONE
    } ctrl_state_t;

    // The sensor code grows with darkness; the inverted form recovers scene
    // brightness, so a saturated pixel reads 0.
    function automatic logic [PIXEL_BITS-1:0] present_code(input logic [PIXEL_BITS-1:0] code);
`ifdef PIXEL_CTRL_SCENE_INVERT_EN
        return PIXEL_BITS'(RAMP_STEPS - 1) - code;
`else
        return code;
`endif
    endfunction

endpackage

// File: rtl/Counter.sv
// Generic up counter with synchronous clear (priority) and count enable.
module Counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Clear wins over enable so a phase change restarts the count at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pixel_capture_bank.sv
// Per-pixel code registers and capture flags. The read port returns the
// value each register will hold after the current edge, so the controller
// can load the first readout word on the same edge that saturates the bank.
module pixel_capture_bank
    import PixelSensorConfig::*;
#(
    parameter int PIXEL_COUNT = 4,
    parameter int IDX_W       = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   sample,
    input  logic                   saturate,
    input  logic [PIXEL_BITS:0]    ramp_count,
    input  logic [PIXEL_COUNT-1:0] cmp,
    input  logic [IDX_W-1:0]       rd_index,
    output logic [PIXEL_BITS-1:0]  rd_code
);

    logic [PIXEL_BITS-1:0]  code_q [PIXEL_COUNT];
    logic [PIXEL_BITS-1:0]  code_d [PIXEL_COUNT];
    logic [PIXEL_COUNT-1:0] flag_q;
    logic [PIXEL_COUNT-1:0] flag_d;
    logic [PIXEL_BITS-1:0]  step_code;

    assign step_code = PIXEL_BITS'(ramp_count - (PIXEL_BITS + 1)'(1));

    // First CMP seen high on pulse k captures k-1; at the end of the ramp any
    // pixel still uncaptured takes the full-scale code.
    always_comb begin
        code_d = code_q;
        flag_d = flag_q;
        for (int i = 0; i < PIXEL_COUNT; i++) begin
            if (clear) begin
                code_d[i] = '0;
                flag_d[i] = 1'b0;
            end else begin
                if (sample && !flag_q[i] && cmp[i]) begin
                    code_d[i] = step_code;
                    flag_d[i] = 1'b1;
                end
                if (saturate && !flag_d[i]) begin
                    code_d[i] = PIXEL_BITS'(RAMP_STEPS - 1);
                    flag_d[i] = 1'b1;
                end
            end
        end
        rd_code = code_d[rd_index];
    end

    // Code and flag storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIXEL_COUNT; i++) begin
                code_q[i] <= '0;
            end
            flag_q <= '0;
        end else begin
            code_q <= code_d;
            flag_q <= flag_d;
        end
    end

endmodule

// File: rtl/pixel_sensor_controller.sv
// Drives ERASE/EXPOSE/RAMP for a row of pixel sensors, converts each pixel's
// CMP edge into a code by counting RAMP pulses, then streams the codes out
// over a valid/ready handshake. Optional build macro:
// PIXEL_CTRL_SCENE_INVERT_EN (codes presented as full-scale minus code).
module pixel_sensor_controller
    import PixelSensorConfig::*;
#(
    parameter  int PIXEL_COUNT   = 4,
    parameter  int EXPOSE_CYCLES = 255,
    localparam int IDX_W         = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PIXEL_COUNT-1:0] CMP,
    output logic                   ERASE,
    output logic                   EXPOSE,
    output logic                   RAMP,
    output logic                   busy,
    output logic [PIXEL_BITS-1:0]  data,
    output logic [IDX_W-1:0]       data_index,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic                   frame_done
);

    ctrl_state_t           state;
    ctrl_state_t           next_state;
    logic [15:0]           phase_count;
    logic [PIXEL_BITS:0]   ramp_count;
    logic                  ramp_low;
    logic                  phase_clear;
    logic                  phase_enable;
    logic                  ramp_clear;
    logic                  ramp_step;
    logic                  sample;
    logic                  saturate;
    logic [IDX_W-1:0]      next_index;
    logic [PIXEL_BITS-1:0] sel_code;

    assign phase_enable = (state == ST_ERASE) || (state == ST_EXPOSE);
    assign ramp_clear   = (state == ST_ERASE);

    Counter #(.WIDTH(16)) u_phase_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (phase_clear),
        .enable (phase_enable),
        .count  (phase_count)
    );

    Counter #(.WIDTH(PIXEL_BITS + 1)) u_ramp_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (ramp_clear),
        .enable (ramp_step),
        .count  (ramp_count)
    );

    pixel_capture_bank #(
        .PIXEL_COUNT (PIXEL_COUNT),
        .IDX_W       (IDX_W)
    ) u_capture_bank (
        .clk        (clk),
        .reset      (reset),
        .clear      (ramp_clear),
        .sample     (sample),
        .saturate   (saturate),
        .ramp_count (ramp_count),
        .cmp        (CMP),
        .rd_index   (next_index),
        .rd_code    (sel_code)
    );

    // Next-state, ramp stepping, capture strobes and readout index selection.
    always_comb begin
        next_state = state;
        ramp_step  = 1'b0;
        sample     = 1'b0;
        saturate   = 1'b0;
        next_index = data_index;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_ERASE;
                end
            end
            ST_ERASE: begin
                if (phase_count == 16'(ERASE_CYCLES - 1)) begin
                    next_state = ST_EXPOSE;
                end
            end
            ST_EXPOSE: begin
                if (phase_count == 16'(EXPOSE_CYCLES - 1)) begin
                    next_state = ST_CONVERT;
                    ramp_step  = 1'b1;
                end
            end
            ST_CONVERT: begin
                if (ramp_low) begin
                    sample = 1'b1;
                    if (ramp_count == (PIXEL_BITS + 1)'(RAMP_STEPS)) begin
                        saturate   = 1'b1;
                        next_state = ST_READOUT;
                        next_index = '0;
                    end else begin
                        ramp_step = 1'b1;
                    end
                end
            end
            ST_READOUT: begin
                if (data_valid && data_ready) begin
                    if (data_index == IDX_W'(PIXEL_COUNT - 1)) begin
                        next_state = ST_DONE;
                    end else begin
                        next_index = data_index + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        phase_clear = (next_state != state);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Tracks which half of the current RAMP pulse we are in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ramp_low <= 1'b0;
        end else if (state == ST_CONVERT) begin
            ramp_low <= !ramp_low;
        end else begin
            ramp_low <= 1'b0;
        end
    end

    // Every output is registered from the upcoming state so strobes line up
    // with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ERASE      <= 1'b0;
            EXPOSE     <= 1'b0;
            RAMP       <= 1'b0;
            busy       <= 1'b0;
            data       <= '0;
            data_index <= '0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            ERASE      <= (next_state == ST_ERASE);
            EXPOSE     <= (next_state == ST_EXPOSE);
            RAMP       <= ramp_step;
            busy       <= (next_state != ST_IDLE);
            data_valid <= (next_state == ST_READOUT);
            frame_done <= (next_state == ST_DONE);
            data_index <= next_index;
            if (next_state == ST_READOUT) begin
                data <= present_code(sel_code);
            end
        end
    end

endmodule

// File: tb/tb_pixel_sensor_controller.sv
// Self-checking bench for pixel_sensor_controller: a table of frame scenarios
// (CMP firing pattern, expected codes, consumer stalls) plus hand-written
// reset-in-convert and start-while-busy sequences.
module tb_pixel_sensor_controller;
    import PixelSensorConfig::*;

    localparam int NPIX = 4;
    localparam int EXP  = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [NPIX-1:0] CMP = '0;
    logic            data_ready = 1'b1;
    logic            ERASE, EXPOSE, RAMP, busy, data_valid, frame_done;
    logic [7:0]      data;
    logic [1:0]      data_index;

    pixel_sensor_controller #(
        .PIXEL_COUNT   (NPIX),
        .EXPOSE_CYCLES (EXP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .CMP        (CMP),
        .ERASE      (ERASE),
        .EXPOSE     (EXPOSE),
        .RAMP       (RAMP),
        .busy       (busy),
        .data       (data),
        .data_index (data_index),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NPIX-1:0][9:0] on1;
        logic [NPIX-1:0][9:0] off1;
        logic [NPIX-1:0][9:0] on2;
        logic [NPIX-1:0][7:0] code;
        int                   stall_word;
        int                   stall_len;
        bit                   poke;
    } frame_t;

    typedef struct {
        int idx;
        int code;
    } word_t;

    frame_t vec [3];
    word_t  sb [$];
    word_t  cur_word;

    int total = 0;
    int bad   = 0;
    int on1 [NPIX];
    int off1 [NPIX];
    int on2 [NPIX];
    int pulse_no = 0;
    logic ramp_prev = 1'b0;
    int accepted = 0;
    int done_seen = 0;
    logic stalled_prev = 1'b0;
    logic [7:0] held_data = '0;
    logic [1:0] held_idx = '0;

    task automatic check(input string name, input int actual, input int required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    function automatic int shown(input int code);
`ifdef PIXEL_CTRL_SCENE_INVERT_EN
        return 255 - code;
`else
        return code;
`endif
    endfunction

    task automatic set_pix(input int f, input int p, input int a, input int b, input int c, input int code);
        vec[f].on1[p]  = 10'(a);
        vec[f].off1[p] = 10'(b);
        vec[f].on2[p]  = 10'(c);
        vec[f].code[p] = 8'(code);
    endtask

    // Pixel model: counts RAMP pulses and raises CMP over the configured windows.
    always @(negedge clk) begin
        if (reset || ERASE) begin
            pulse_no = 0;
        end else if (RAMP && !ramp_prev) begin
            pulse_no = pulse_no + 1;
        end
        ramp_prev = RAMP;
        for (int i = 0; i < NPIX; i++) begin
            CMP[i] = ((pulse_no >= on1[i]) && (pulse_no < off1[i])) || (pulse_no >= on2[i]);
        end
    end

    // Output monitor: scoreboard comparison on every transfer and hold checks while stalled.
    always @(negedge clk) begin
        if (!reset) begin
            if (stalled_prev) begin
                check("hold_data", int'(data), int'(held_data));
                check("hold_index", int'(data_index), int'(held_idx));
                check("hold_valid", int'(data_valid), 1);
            end
            if (data_valid && data_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL extra_word: got index %0d data %0d, required no word", data_index, data);
                end else begin
                    cur_word = sb.pop_front();
                    check("word_index", int'(data_index), cur_word.idx);
                    check("word_data", int'(data), cur_word.code);
                end
                accepted++;
            end
            stalled_prev = data_valid && !data_ready;
            held_data    = data;
            held_idx     = data_index;
            if (frame_done) begin
                done_seen++;
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic load_pixels(input int f);
        for (int p = 0; p < NPIX; p++) begin
            on1[p]  = int'(vec[f].on1[p]);
            off1[p] = int'(vec[f].off1[p]);
            on2[p]  = int'(vec[f].on2[p]);
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, "_ERASE"}, int'(ERASE), 0);
        check({tag, "_EXPOSE"}, int'(EXPOSE), 0);
        check({tag, "_RAMP"}, int'(RAMP), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_data"}, int'(data), 0);
        check({tag, "_index"}, int'(data_index), 0);
        check({tag, "_valid"}, int'(data_valid), 0);
        check({tag, "_done"}, int'(frame_done), 0);
    endtask

    task automatic apply_stimulus(input int f);
        int n;
        int guard;
        int stalled;
        int acc0;
        int done0;
        load_pixels(f);
        for (int p = 0; p < NPIX; p++) begin
            sb.push_back('{idx: p, code: shown(int'(vec[f].code[p]))});
        end
        acc0  = accepted;
        done0 = done_seen;
        data_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (n = 1; n <= 600; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("erase_c1", int'(ERASE), 1);
                check("busy_c1", int'(busy), 1);
            end
            if (n == 2) check("erase_c2", int'(ERASE), 1);
            if (n == 3) begin
                check("erase_off", int'(ERASE), 0);
                check("expose_on", int'(EXPOSE), 1);
            end
            if (n == EXP + 2) check("expose_last", int'(EXPOSE), 1);
            if (n == EXP + 3) begin
                check("expose_off", int'(EXPOSE), 0);
                check("ramp_first_hi", int'(RAMP), 1);
            end
            if (n == EXP + 4) check("ramp_first_lo", int'(RAMP), 0);
            if (vec[f].poke && n == 4) start = 1'b1;
            if (n == 5) start = 1'b0;
            if (data_valid) break;
        end
        check("first_valid_latency", n, 3 + EXP + 512);
        stalled = 0;
        for (guard = 0; guard < 100; guard++) begin
            @(posedge clk);
            #1;
            if ((accepted - acc0) == vec[f].stall_word && stalled < vec[f].stall_len) begin
                data_ready = 1'b0;
                stalled++;
            end else begin
                data_ready = 1'b1;
            end
            start = (vec[f].poke && guard == 1);
            @(negedge clk);
            if (frame_done) break;
        end
        start = 1'b0;
        #1;
        check("frame_done_count", done_seen - done0, 1);
        check("words_accepted", accepted - acc0, NPIX);
        check("scoreboard_drained", sb.size(), 0);
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
        check("done_one_cycle", int'(frame_done), 0);
        repeat (10) @(negedge clk);
        check("start_not_queued", int'(busy), 0);
        check("no_extra_done", done_seen - done0, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        int done0;
        for (int p = 0; p < NPIX; p++) begin
            on1[p] = 1000; off1[p] = 1000; on2[p] = 1000;
        end
        set_pix(0, 0, 1000, 1000, 1, 0);
        set_pix(0, 1, 1000, 1000, 18, 17);
        set_pix(0, 2, 1000, 1000, 129, 128);
        set_pix(0, 3, 1000, 1000, 256, 255);
        vec[0].stall_word = -1; vec[0].stall_len = 0; vec[0].poke = 1'b0;
        set_pix(1, 0, 1000, 1000, 1, 0);
        set_pix(1, 1, 1000, 1000, 18, 17);
        set_pix(1, 2, 1000, 1000, 1000, 255);
        set_pix(1, 3, 1000, 1000, 51, 50);
        vec[1].stall_word = 1; vec[1].stall_len = 5; vec[1].poke = 1'b0;
        set_pix(2, 0, 10, 11, 40, 9);
        set_pix(2, 1, 1000, 1000, 2, 1);
        set_pix(2, 2, 1000, 1000, 256, 255);
        set_pix(2, 3, 1000, 1000, 0, 0);
        vec[2].stall_word = 2; vec[2].stall_len = 1; vec[2].poke = 1'b1;

        repeat (3) @(negedge clk);
        check_output("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        for (int f = 0; f < 3; f++) begin
            $display("[TB] frame scenario %0d", f);
            apply_stimulus(f);
        end

        $display("[TB] reset during convert");
        load_pixels(0);
        done0 = done_seen;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (guard = 0; guard < 700; guard++) begin
            @(negedge clk);
            if (pulse_no == 100) break;
        end
        check("reached_pulse_100", pulse_no, 100);
        check("busy_in_convert", int'(busy), 1);
        reset = 1'b1;
        #1;
        check_output("midreset");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("no_done_after_reset", done_seen - done0, 0);
        check("idle_after_reset", int'(busy), 0);
        apply_stimulus(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
